mem_bus_arbiter: RTL and testbench

Two-port arbiter sharing the core memory bus between instruction fetch (IF) and data memory (DM) requesters. Sits between the pipeline's fetch/load-store units and the fixed-latency core memory bus; registers one granted request toward the bus, records the owner of each outstanding request in an in-order owner FIFO, and steers each returning bus response back to its owner. The bus returns responses strictly in request order; every request (read or write) yields exactly one response.

---
 rtl/mem_bus_arbiter.sv | 91 +++++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: IF/DM arbiter onto the core memory bus with an in-order owner FIFO; define MEM_ARB_ROUND_ROBIN_EN for round-robin grant (default: DM fixed priority).
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    if_req_valid,
   output logic                    if_req_ready,
   input  logic [ADDR_WIDTH-1:0]   if_req_addr,
   input  logic                    dm_req_valid,
   output logic                    dm_req_ready,
   input  logic                    dm_req_write,
   input  logic [ADDR_WIDTH-1:0]   dm_req_addr,
   input  logic [DATA_WIDTH-1:0]   dm_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] dm_req_wstrb,
   output logic                    bus_req_valid,
   input  logic                    bus_req_ready,
   output logic                    bus_req_write,
   output logic [ADDR_WIDTH-1:0]   bus_req_addr,
   output logic [DATA_WIDTH-1:0]   bus_req_wdata,
   output logic [DATA_WIDTH/8-1:0] bus_req_wstrb,
   input  logic                    bus_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   bus_rsp_data,
   output logic                    if_rsp_valid,
   output logic [DATA_WIDTH-1:0]   if_rsp_data,
   output logic                    dm_rsp_valid,
   output logic [DATA_WIDTH-1:0]   dm_rsp_data,
   output logic                    arb_err
);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   logic                       full;
   logic [CW-1:0]              count;
   logic [PW-1:0]              wr_ptr, rd_ptr;
   logic [MAX_OUTSTANDING-1:0] owner;
   logic [DATA_WIDTH-1:0]      rsp_data;
   logic                       dm_sel, slot, accept, pop;
   assign bus_req_valid = full;
   assign slot          = reset && (!full || bus_req_ready) && (count < CW'(MAX_OUTSTANDING));
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_dm;
   assign dm_sel = dm_req_valid && (!if_req_valid || !last_dm);
   always_ff @(posedge clock or negedge reset)
      if (!reset) last_dm <= 1'b0;
      else if (accept) last_dm <= dm_sel;
`else
   assign dm_sel = dm_req_valid;
`endif
   assign dm_req_ready = slot && dm_sel;
   assign if_req_ready = slot && if_req_valid && !dm_sel;
   assign accept       = dm_req_ready || if_req_ready;
   assign pop          = bus_rsp_valid && |count;
   assign if_rsp_data  = rsp_data;
   assign dm_rsp_data  = rsp_data;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         full          <= 1'b0;
         bus_req_write <= 1'b0;
         bus_req_addr  <= '0;
         bus_req_wdata <= '0;
         bus_req_wstrb <= '0;
         count         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         owner         <= '0;
         if_rsp_valid  <= 1'b0;
         dm_rsp_valid  <= 1'b0;
         rsp_data      <= '0;
         arb_err       <= 1'b0;
      end else begin
         if (accept) begin
            full          <= 1'b1;
            bus_req_write <= dm_sel && dm_req_write;
            bus_req_addr  <= dm_sel ? dm_req_addr : if_req_addr;
            bus_req_wdata <= dm_sel ? dm_req_wdata : '0;
            bus_req_wstrb <= dm_sel ? dm_req_wstrb : '0;
            owner[wr_ptr] <= dm_sel;
            wr_ptr        <= wr_ptr + 1'b1;
         end else if (bus_req_ready) full <= 1'b0;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            rsp_data <= bus_rsp_data;
         end
         count        <= count + CW'(accept) - CW'(pop);
         if_rsp_valid <= pop && !owner[rd_ptr];
         dm_rsp_valid <= pop && owner[rd_ptr];
         if (bus_rsp_valid && !(|count)) arb_err <= 1'b1;
      end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (bus requests and responses checked against queued expectations).
module tb_mem_bus_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready, dm_req_valid, dm_req_ready, dm_req_write;
   logic [31:0] if_req_addr, dm_req_addr, dm_req_wdata;
   logic [3:0]  dm_req_wstrb;
   logic        bus_req_valid, bus_req_ready, bus_req_write;
   logic [31:0] bus_req_addr, bus_req_wdata;
   logic [3:0]  bus_req_wstrb;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_data;
   logic        if_rsp_valid, dm_rsp_valid, arb_err;
   logic [31:0] if_rsp_data, dm_rsp_data;
   logic [68:0] bus_q[$];
   logic [32:0] rsp_q[$];
   bit          own_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          exp_dm;
   mem_bus_arbiter dut (
      .clock(clock), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_write(dm_req_write),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .arb_err(arb_err)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask
   task automatic issue_if(input logic [31:0] a);
      if_req_valid = 1'b1;
      if_req_addr  = a;
      @(negedge clock);
      chk("if_rdy", if_req_ready, 1'b1);
      chk("if_dm_rdy", dm_req_ready, 1'b0);
      bus_q.push_back({1'b0, a, 32'h0, 4'h0});
      own_q.push_back(1'b0);
      cyc();
      if_req_valid = 1'b0;
   endtask
   task automatic issue_dm(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      dm_req_valid = 1'b1;
      dm_req_write = w;
      dm_req_addr  = a;
      dm_req_wdata = d;
      dm_req_wstrb = s;
      @(negedge clock);
      chk("dm_rdy", dm_req_ready, 1'b1);
      chk("dm_if_rdy", if_req_ready, 1'b0);
      bus_q.push_back({w, a, d, s});
      own_q.push_back(1'b1);
      cyc();
      dm_req_valid = 1'b0;
   endtask
   task automatic start_rsp(input logic [31:0] d);
      rsp_q.push_back({own_q.pop_front(), d});
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = d;
   endtask
   task automatic respond(input logic [31:0] d);
      start_rsp(d);
      cyc();
      bus_rsp_valid = 1'b0;
   endtask
   always @(negedge clock) begin
      if (bus_req_valid && bus_req_ready) begin
         if (bus_q.size() == 0) chk("bus_unexpected", 1'b1, 1'b0);
         else chk("bus_req", {bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb}, bus_q.pop_front());
      end
      if (if_rsp_valid && dm_rsp_valid) chk("rsp_both", 1'b1, 1'b0);
      else if (if_rsp_valid || dm_rsp_valid) begin
         if (rsp_q.size() == 0) chk("rsp_unexpected", 1'b1, 1'b0);
         else chk("rsp", {dm_rsp_valid, dm_rsp_valid ? dm_rsp_data : if_rsp_data}, rsp_q.pop_front());
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end
   initial begin
      reset = 1'b0;
      if_req_valid = 1'b1; if_req_addr = '0;
      dm_req_valid = 1'b1; dm_req_write = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wstrb = '0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;
      @(negedge clock);
      chk("rst_if_rdy", if_req_ready, 1'b0);
      chk("rst_dm_rdy", dm_req_ready, 1'b0);
      chk("rst_bus", {bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb}, '0);
      chk("rst_rsp", {if_rsp_valid, dm_rsp_valid, if_rsp_data, dm_rsp_data, arb_err}, '0);
      cyc();
      reset = 1'b1; if_req_valid = 1'b0; dm_req_valid = 1'b0; bus_req_ready = 1'b1;
      cyc();
      // single fetch read
      issue_if(32'h100);
      @(negedge clock);
      chk("t1_bus_vld", bus_req_valid, 1'b1);
      cyc();
      respond(32'hDEADBEEF);
      @(negedge clock);
      chk("t1_if_rsp", if_rsp_valid, 1'b1);
      chk("t1_dm_rsp", dm_rsp_valid, 1'b0);
      cyc();
      @(negedge clock);
      chk("t1_if_rsp_once", if_rsp_valid, 1'b0);
      cyc();
      // conflict until the FIFO fills
      if_req_valid = 1'b1; if_req_addr = 32'h300;
      dm_req_valid = 1'b1; dm_req_write = 1'b1; dm_req_addr = 32'h200; dm_req_wdata = 32'hA5; dm_req_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_dm = (i % 2 == 0);
`else
         exp_dm = 1'b1;
`endif
         @(negedge clock);
         chk("t2_dm_rdy", dm_req_ready, exp_dm);
         chk("t2_if_rdy", if_req_ready, !exp_dm);
         bus_q.push_back(exp_dm ? {1'b1, 32'h200, 32'hA5, 4'hF} : {1'b0, 32'h300, 32'h0, 4'h0});
         own_q.push_back(exp_dm);
         cyc();
      end
      repeat (2) begin
         @(negedge clock);
         chk("t3_full_dm", dm_req_ready, 1'b0);
         chk("t3_full_if", if_req_ready, 1'b0);
         cyc();
      end
      start_rsp(32'h11);
      @(negedge clock);
      chk("t3_pop_dm", dm_req_ready, 1'b0);
      chk("t3_pop_if", if_req_ready, 1'b0);
      cyc();
      bus_rsp_valid = 1'b0;
      @(negedge clock);
      chk("t3_resume_dm", dm_req_ready, 1'b1);
      chk("t3_resume_if", if_req_ready, 1'b0);
      bus_q.push_back({1'b1, 32'h200, 32'hA5, 4'hF});
      own_q.push_back(1'b1);
      cyc();
      if_req_valid = 1'b0; dm_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) respond(32'h20 + i);
      cyc();
      // stalled store
      bus_req_ready = 1'b0;
      issue_dm(1'b1, 32'h40, 32'h55AA, 4'h3);
      if_req_valid = 1'b1; if_req_addr = 32'h300;
      repeat (3) begin
         @(negedge clock);
         chk("t4_stall_fields", {bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb}, {1'b1, 1'b1, 32'h40, 32'h55AA, 4'h3});
         chk("t4_stall_if_rdy", if_req_ready, 1'b0);
         cyc();
      end
      bus_req_ready = 1'b1; if_req_valid = 1'b0;
      cyc();
      @(negedge clock);
      chk("t4_bus_idle", bus_req_valid, 1'b0);
      cyc();
      respond(32'h77);
      cyc();
      // interleaved owners
      issue_if(32'h104);
      issue_dm(1'b0, 32'h80, 32'h0, 4'h0);
      issue_if(32'h108);
      respond(32'h1);
      respond(32'h2);
      respond(32'h3);
      cyc();
      cyc();
      // spurious response
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'h99;
      cyc();
      bus_rsp_valid = 1'b0;
      @(negedge clock);
      chk("t6_no_rsp", {if_rsp_valid, dm_rsp_valid}, 2'b00);
      chk("t6_err", arb_err, 1'b1);
      repeat (3) cyc();
      chk("t6_err_sticky", arb_err, 1'b1);
      // async reset mid-cycle
      bus_req_ready = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 32'h500;
      @(negedge clock);
      chk("t7_if_rdy", if_req_ready, 1'b1);
      cyc();
      @(negedge clock);
      chk("t7_bus_vld", bus_req_valid, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("t7_rst_bus", {bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb}, '0);
      chk("t7_rst_out", {if_rsp_valid, dm_rsp_valid, arb_err, if_req_ready, dm_req_ready}, '0);
      cyc();
      reset = 1'b1; if_req_valid = 1'b0;
      cyc();
      @(negedge clock);
      chk("t7_post_bus", bus_req_valid, 1'b0);
      chk("bus_q_drained", bus_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
